// File: rtl/reg_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : reg_op_sequencer
// Purpose  : Expands host macro commands into single-cycle control pulses for
//            one 4-bit control register and reports the read-back result.
// Revision : 1.0 - initial release
// ============================================================================
module reg_op_sequencer #(
  parameter int MAX_STEPS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [3:0] cmd_data,
  input  logic [3:0] cmd_cnt,
  input  logic [3:0] reg_q,
  output logic       reg_cl,
  output logic       reg_ld,
  output logic       reg_inc,
  output logic       reg_dec,
  output logic       reg_sr,
  output logic       reg_sl,
  output logic [3:0] reg_in,
  output logic       reg_ir,
  output logic       reg_il,
  output logic       busy,
  output logic       done,
  output logic [3:0] result,
  output logic       err
);

  // Step counter must hold both a 4-bit repeat count and MAX_STEPS.
  localparam int SW = ($clog2(MAX_STEPS + 1) > 4) ? $clog2(MAX_STEPS + 1) : 4;

  localparam logic [2:0] c_OP_NOP  = 3'd0;
  localparam logic [2:0] c_OP_CLR  = 3'd1;
  localparam logic [2:0] c_OP_LD   = 3'd2;
  localparam logic [2:0] c_OP_INC  = 3'd3;
  localparam logic [2:0] c_OP_DEC  = 3'd4;
  localparam logic [2:0] c_OP_SHR  = 3'd5;
  localparam logic [2:0] c_OP_ROTL = 3'd6;
  localparam logic [2:0] c_OP_CNT  = 3'd7;

  localparam logic [SW-1:0] c_MAX_STEPS = SW'(MAX_STEPS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        r_state;
  logic [2:0]    r_op;
  logic [3:0]    r_data;
  logic [3:0]    r_cnt;
  logic [SW-1:0] r_step;
  logic [3:0]    r_result;
  logic          r_err;

  logic          w_exec;
  logic          w_cnt_zero;
  logic          w_rep_op;
  logic [SW-1:0] w_step_nxt;
  logic          w_rep_last;
  logic          w_eq;
  logic          w_abort;
  logic          w_exec_end;

  assign w_exec     = (r_state == S_EXEC);
  assign w_cnt_zero = (r_cnt == 4'd0);
  assign w_rep_op   = (r_op == c_OP_INC) || (r_op == c_OP_DEC) ||
                      (r_op == c_OP_SHR) || (r_op == c_OP_ROTL);
  assign w_step_nxt = r_step + 1'b1;
  assign w_rep_last = w_cnt_zero || (w_step_nxt == SW'(r_cnt));
  assign w_eq       = (reg_q == r_data);
  assign w_abort    = !w_eq && (r_step == c_MAX_STEPS);

  always_comb begin
    w_exec_end = 1'b1;
    if (w_rep_op) begin
      w_exec_end = w_rep_last;
    end else if (r_op == c_OP_CNT) begin
      w_exec_end = w_eq || w_abort;
    end
  end

  // Register controls are pure decodes so the pulse lands in the EXEC cycle.
  always_comb begin
    reg_cl  = 1'b0;
    reg_ld  = 1'b0;
    reg_inc = 1'b0;
    reg_dec = 1'b0;
    reg_sr  = 1'b0;
    reg_sl  = 1'b0;
    reg_in  = 4'd0;
    reg_ir  = 1'b0;
    reg_il  = 1'b0;
    if (w_exec) begin
      case (r_op)
        c_OP_NOP: ;
        c_OP_CLR: reg_cl = 1'b1;
        c_OP_LD: begin
          reg_ld = 1'b1;
          reg_in = r_data;
        end
        c_OP_INC: reg_inc = !w_cnt_zero;
        c_OP_DEC: reg_dec = !w_cnt_zero;
        c_OP_SHR: begin
          reg_sr = !w_cnt_zero;
          reg_ir = !w_cnt_zero && r_data[0];
        end
        c_OP_ROTL: begin
          reg_sl = !w_cnt_zero;
          reg_il = !w_cnt_zero && reg_q[3];
        end
        c_OP_CNT: reg_inc = !w_eq && !w_abort;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_op     <= 3'd0;
      r_data   <= 4'd0;
      r_cnt    <= 4'd0;
      r_step   <= '0;
      r_result <= 4'd0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_op    <= cmd_op;
            r_data  <= cmd_data;
            r_cnt   <= cmd_cnt;
            r_step  <= '0;
            r_err   <= 1'b0;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (w_exec_end) begin
            r_err   <= (r_op == c_OP_CNT) && w_abort;
            r_state <= S_DONE;
          end else begin
            r_step  <= w_step_nxt;
          end
        end
        S_DONE: begin
          r_result <= reg_q;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // The last pulse updates the register at the EXEC->DONE edge, so during
  // DONE the settled value is only visible on reg_q; it is held afterwards.
  assign cmd_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign result    = done ? reg_q : r_result;
  assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_reg_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_op_sequencer
// Purpose  : Directed self-checking bench with a behavioural 4-bit register.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_op_sequencer;

  localparam int MAX_STEPS = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_op = 3'd0;
  logic [3:0] cmd_data = 4'd0;
  logic [3:0] cmd_cnt = 4'd0;
  logic [3:0] reg_q;
  logic       reg_cl, reg_ld, reg_inc, reg_dec, reg_sr, reg_sl;
  logic [3:0] reg_in;
  logic       reg_ir, reg_il;
  logic       busy, done, err;
  logic [3:0] result;

  always #5 clk = ~clk;

  reg_op_sequencer #(.MAX_STEPS(MAX_STEPS)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_cnt(cmd_cnt),
    .reg_q(reg_q),
    .reg_cl(reg_cl), .reg_ld(reg_ld), .reg_inc(reg_inc), .reg_dec(reg_dec),
    .reg_sr(reg_sr), .reg_sl(reg_sl), .reg_in(reg_in),
    .reg_ir(reg_ir), .reg_il(reg_il),
    .busy(busy), .done(done), .result(result), .err(err)
  );

  // Behavioural control register driven only by the sequencer.
  logic [3:0] m_q = 4'h0;
  assign reg_q = m_q;
  always @(posedge clk) begin
    if (reg_cl)       m_q <= 4'h0;
    else if (reg_ld)  m_q <= reg_in;
    else if (reg_inc) m_q <= m_q + 4'd1;
    else if (reg_dec) m_q <= m_q - 4'd1;
    else if (reg_sr)  m_q <= {reg_ir, m_q[3:1]};
    else if (reg_sl)  m_q <= {m_q[2:0], reg_il};
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  int n_cl, n_ld, n_inc, n_dec, n_sr, n_sl, n_multi, n_side, n_ctl_done, lat, n_rdy_low;
  logic got_done;
  logic [3:0] res;
  logic res_err;

  function automatic int ctl_sum();
    return int'(reg_cl) + int'(reg_ld) + int'(reg_inc) + int'(reg_dec) + int'(reg_sr) + int'(reg_sl);
  endfunction

  // Issue one command and watch every cycle until done (bounded).
  task automatic run_cmd(input logic [2:0] op, input logic [3:0] d, input logic [3:0] c, input bit junk);
    int guard;
    int nctl;
    guard = 0;
    while (!cmd_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    cmd_valid = 1'b1; cmd_op = op; cmd_data = d; cmd_cnt = c;
    @(posedge clk); #1;
    if (junk) begin
      cmd_op = 3'd3; cmd_data = 4'hF; cmd_cnt = 4'd5;
    end else begin
      cmd_valid = 1'b0;
    end
    n_cl = 0; n_ld = 0; n_inc = 0; n_dec = 0; n_sr = 0; n_sl = 0;
    n_multi = 0; n_side = 0; n_ctl_done = 0; lat = 0; n_rdy_low = 0;
    got_done = 1'b0; res = 4'h0; res_err = 1'b0;
    for (int i = 0; i < 40 && !got_done; i++) begin
      @(negedge clk);
      lat++;
      nctl = ctl_sum();
      if (!cmd_ready) n_rdy_low++;
      if (nctl > 1) n_multi++;
      if (reg_ld ? (reg_in !== d) : (reg_in !== 4'h0)) n_side++;
      if (reg_sr ? (reg_ir !== d[0]) : (reg_ir !== 1'b0)) n_side++;
      if (reg_sl ? (reg_il !== reg_q[3]) : (reg_il !== 1'b0)) n_side++;
      if (done) begin
        got_done = 1'b1;
        res = result;
        res_err = err;
        n_ctl_done = nctl;
        cmd_valid = 1'b0;
      end else begin
        n_cl += int'(reg_cl); n_ld += int'(reg_ld); n_inc += int'(reg_inc);
        n_dec += int'(reg_dec); n_sr += int'(reg_sr); n_sl += int'(reg_sl);
      end
    end
    chk("done_seen", got_done, 1);
    chk("no_ctl_in_done", n_ctl_done, 0);
    chk("onehot", n_multi, 0);
    chk("side_fields", n_side, 0);
    @(negedge clk);
    chk("ready_after_done", cmd_ready, 1);
  endtask

  initial begin
    int cnt;
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_err", err, 0);
    chk("rst_ctl", {reg_cl, reg_ld, reg_inc, reg_dec, reg_sr, reg_sl, reg_ir, reg_il, reg_in}, 0);
    rst = 1'b0;
    @(negedge clk);

    // LD 0xA
    run_cmd(3'd2, 4'hA, 4'd0, 1'b0);
    chk("ld_pulses", n_ld, 1);
    chk("ld_others", n_cl + n_inc + n_dec + n_sr + n_sl, 0);
    chk("ld_latency", lat, 2);
    chk("ld_ready_low", n_rdy_low, 2);
    chk("ld_result", res, 4'hA);
    chk("ld_err", res_err, 0);
    chk("ld_result_hold", result, 4'hA);

    // INC x3 from 0xE wraps to 0x1
    run_cmd(3'd2, 4'hE, 4'd0, 1'b0);
    run_cmd(3'd3, 4'h0, 4'd3, 1'b0);
    chk("inc_pulses", n_inc, 3);
    chk("inc_others", n_cl + n_ld + n_dec + n_sr + n_sl, 0);
    chk("inc_latency", lat, 4);
    chk("inc_result", res, 4'h1);

    // ROTL x2 of 1001 -> 0110, then SHR x1 fill 1 -> 1011
    run_cmd(3'd2, 4'h9, 4'd0, 1'b0);
    run_cmd(3'd6, 4'h0, 4'd2, 1'b0);
    chk("rotl_pulses", n_sl, 2);
    chk("rotl_result", res, 4'h6);
    run_cmd(3'd5, 4'h1, 4'd1, 1'b0);
    chk("shr_pulses", n_sr, 1);
    chk("shr_result", res, 4'hB);

    // DEC x3 from 2 wraps to 0xF
    run_cmd(3'd2, 4'h2, 4'd0, 1'b0);
    run_cmd(3'd4, 4'h0, 4'd3, 1'b0);
    chk("dec_pulses", n_dec, 3);
    chk("dec_result", res, 4'hF);

    // CNT_TO 3 -> 5
    run_cmd(3'd2, 4'h3, 4'd0, 1'b0);
    run_cmd(3'd7, 4'h5, 4'd0, 1'b0);
    chk("cnt_pulses", n_inc, 2);
    chk("cnt_latency", lat, 4);
    chk("cnt_result", res, 4'h5);
    chk("cnt_err", res_err, 0);

    // CLR then CNT_TO 12 aborts after MAX_STEPS incs
    run_cmd(3'd1, 4'h0, 4'd0, 1'b0);
    chk("clr_pulses", n_cl, 1);
    chk("clr_result", res, 4'h0);
    run_cmd(3'd7, 4'hC, 4'd0, 1'b0);
    chk("abort_pulses", n_inc, MAX_STEPS);
    chk("abort_latency", lat, MAX_STEPS + 2);
    chk("abort_result", res, 4'h8);
    chk("abort_err", res_err, 1);
    chk("abort_err_hold", err, 1);

    // INC cnt=0 with junk held on cmd_* while busy, then NOP
    run_cmd(3'd3, 4'h0, 4'd0, 1'b1);
    chk("inc0_pulses", n_cl + n_ld + n_inc + n_dec + n_sr + n_sl, 0);
    chk("inc0_latency", lat, 2);
    chk("inc0_result", res, 4'h8);
    chk("inc0_err_cleared", res_err, 0);
    chk("junk_ignored_busy", busy, 0);
    chk("junk_ignored_reg", reg_q, 4'h8);
    run_cmd(3'd0, 4'h3, 4'd7, 1'b0);
    chk("nop_pulses", n_cl + n_ld + n_inc + n_dec + n_sr + n_sl, 0);
    chk("nop_latency", lat, 2);
    chk("nop_result", res, 4'h8);

    // Reset mid INC x10 after 4 incs
    run_cmd(3'd2, 4'h5, 4'd0, 1'b0);
    cmd_valid = 1'b1; cmd_op = 3'd3; cmd_data = 4'h0; cmd_cnt = 4'd10;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cnt = 0;
    for (int i = 0; i < 12 && cnt < 4; i++) begin
      @(negedge clk);
      if (reg_inc) cnt++;
    end
    chk("midrst_incs_seen", cnt, 4);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_ctl", {reg_cl, reg_ld, reg_inc, reg_dec, reg_sr, reg_sl, reg_ir, reg_il, reg_in}, 0);
    chk("midrst_ready", cmd_ready, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_reg", reg_q, 4'h9);
    rst = 1'b0;
    @(negedge clk);

    run_cmd(3'd2, 4'h7, 4'd0, 1'b0);
    chk("post_rst_ld", res, 4'h7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
